// File: rtl/dataflow_deadlock_arbiter.sv
// Central arbiter of the dataflow deadlock-detection protocol: nominates one origin claim,
// confirms it persists and broadcasts a sticky dl_detect_out. Optional macro: DL_CYCLE_STAMP_EN.
module dataflow_deadlock_arbiter #(
    parameter int PROC_NUM       = 2,
    parameter int CONFIRM_CYCLES = 4,
    parameter int CNT_W          = 32,
    localparam int IDX_W         = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin,
    output logic                token_clear,
    output logic [IDX_W-1:0]    dl_proc_idx,
`ifdef DL_CYCLE_STAMP_EN
    output logic [CNT_W-1:0]    detect_cycle,
`endif
    output logic                busy
);

    localparam int CW = $clog2(CONFIRM_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CLEAR    = 2'd2,
        DETECTED = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         confirm_cnt, confirm_cnt_n, confirm_inc;
    logic [PROC_NUM-1:0]   origin_n, low_onehot;
    logic [IDX_W-1:0]      idx_n, low_idx;
    logic                  detect_n, token_n;

    // Lowest-index claim wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        low_idx    = '0;
        low_onehot = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_in_vec[i]) begin
                low_idx       = IDX_W'(i);
                low_onehot    = '0;
                low_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        origin_n      = origin;
        idx_n         = dl_proc_idx;
        confirm_cnt_n = confirm_cnt;
        detect_n      = dl_detect_out;
        token_n       = 1'b0;
        confirm_inc   = confirm_cnt + CW'(1);
        case (state)
            IDLE: begin
                if (dl_in_vec != '0) begin
                    origin_n      = low_onehot;
                    idx_n         = low_idx;
                    confirm_cnt_n = CW'(1);
                    if (CONFIRM_CYCLES == 1) begin
                        detect_n = 1'b1;
                        state_n  = DETECTED;
                    end else begin
                        state_n  = ARMED;
                    end
                end
            end
            ARMED: begin
                if (dl_in_vec[dl_proc_idx]) begin
                    confirm_cnt_n = confirm_inc;
                    if (confirm_inc == CW'(CONFIRM_CYCLES)) begin
                        detect_n = 1'b1;
                        state_n  = DETECTED;
                    end
                end else begin
                    origin_n = '0;
                    token_n  = 1'b1;
                    state_n  = CLEAR;
                end
            end
            // One-cycle re-arm gap: claims are not sampled here.
            CLEAR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = DETECTED;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            confirm_cnt   <= '0;
            origin        <= '0;
            dl_proc_idx   <= '0;
            dl_detect_out <= 1'b0;
            token_clear   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            confirm_cnt   <= confirm_cnt_n;
            origin        <= origin_n;
            dl_proc_idx   <= idx_n;
            dl_detect_out <= detect_n;
            token_clear   <= token_n;
            busy          <= (state_n != IDLE);
        end
    end

`ifdef DL_CYCLE_STAMP_EN
    logic [CNT_W-1:0] cycle_cnt, cycle_cnt_n;

    assign cycle_cnt_n = cycle_cnt + CNT_W'(1);

    // Stamp carries the count including the edge that enters DETECTED.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt    <= '0;
            detect_cycle <= '0;
        end else begin
            cycle_cnt <= cycle_cnt_n;
            if (state != DETECTED && state_n == DETECTED) begin
                detect_cycle <= cycle_cnt_n;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dataflow_deadlock_arbiter.sv
// Self-checking bench for dataflow_deadlock_arbiter: directed scenarios plus randomized
// claims compared against a transaction-level model of the arbitration rules.
module tb_dataflow_deadlock_arbiter;

    localparam int PROC_NUM       = 2;
    localparam int CONFIRM_CYCLES = 4;
    localparam int CNT_W          = 32;
    localparam int IDX_W          = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;

    logic                clock;
    logic                reset;
    logic [PROC_NUM-1:0] dl_in_vec;
    logic                dl_detect_out;
    logic [PROC_NUM-1:0] origin;
    logic                token_clear;
    logic [IDX_W-1:0]    dl_proc_idx;
    logic                busy;
`ifdef DL_CYCLE_STAMP_EN
    logic [CNT_W-1:0]    detect_cycle;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: which process holds the nomination (-1 none), how many consecutive samples
    // have seen it high, whether the re-arm gap is pending, and whether deadlock is declared.
    int               m_origin;
    int               m_last_idx;
    int               m_streak;
    bit               m_detect;
    bit               m_gap;
    bit               m_token;
    logic [CNT_W-1:0] m_cycle;
    logic [CNT_W-1:0] m_stamp;

    dataflow_deadlock_arbiter #(
        .PROC_NUM      (PROC_NUM),
        .CONFIRM_CYCLES(CONFIRM_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dl_in_vec    (dl_in_vec),
        .dl_detect_out(dl_detect_out),
        .origin       (origin),
        .token_clear  (token_clear),
        .dl_proc_idx  (dl_proc_idx),
`ifdef DL_CYCLE_STAMP_EN
        .detect_cycle (detect_cycle),
`endif
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_origin   = -1;
        m_last_idx = 0;
        m_streak   = 0;
        m_detect   = 1'b0;
        m_gap      = 1'b0;
        m_token    = 1'b0;
        m_cycle    = '0;
        m_stamp    = '0;
    endtask

    task automatic model_edge(input logic [PROC_NUM-1:0] v);
        m_cycle = m_cycle + 1'b1;
        m_token = 1'b0;
        if (m_detect) begin
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_origin < 0) begin
            for (int i = 0; i < PROC_NUM; i++) begin
                if (v[i] && m_origin < 0) m_origin = i;
            end
            if (m_origin >= 0) begin
                m_last_idx = m_origin;
                m_streak   = 1;
            end
        end else if (v[m_origin]) begin
            m_streak++;
        end else begin
            m_origin = -1;
            m_streak = 0;
            m_token  = 1'b1;
            m_gap    = 1'b1;
        end
        if (!m_detect && m_origin >= 0 && m_streak >= CONFIRM_CYCLES) begin
            m_detect = 1'b1;
            m_stamp  = m_cycle;
        end
    endtask

    task automatic check_output(input string tag);
        logic [PROC_NUM-1:0] exp_origin;
        logic [IDX_W-1:0]    exp_idx;
        logic                exp_busy;
        exp_origin = '0;
        if (m_origin >= 0) exp_origin[m_origin] = 1'b1;
        exp_idx  = IDX_W'(m_last_idx);
        exp_busy = (m_origin >= 0) || m_gap;

        checks++;
        assert (dl_detect_out === m_detect) else begin
            failures++;
            $error("FAIL %s.detect observed=%0b expected=%0b", tag, dl_detect_out, m_detect);
        end
        checks++;
        assert (origin === exp_origin) else begin
            failures++;
            $error("FAIL %s.origin observed=%b expected=%b", tag, origin, exp_origin);
        end
        checks++;
        assert (token_clear === m_token) else begin
            failures++;
            $error("FAIL %s.token_clear observed=%0b expected=%0b", tag, token_clear, m_token);
        end
        checks++;
        assert (dl_proc_idx === exp_idx) else begin
            failures++;
            $error("FAIL %s.dl_proc_idx observed=%0d expected=%0d", tag, dl_proc_idx, exp_idx);
        end
        checks++;
        assert (busy === exp_busy) else begin
            failures++;
            $error("FAIL %s.busy observed=%0b expected=%0b", tag, busy, exp_busy);
        end
`ifdef DL_CYCLE_STAMP_EN
        checks++;
        assert (detect_cycle === m_stamp) else begin
            failures++;
            $error("FAIL %s.detect_cycle observed=%0d expected=%0d", tag, detect_cycle, m_stamp);
        end
`endif
    endtask

    task automatic apply_stimulus(input logic [PROC_NUM-1:0] v, input string tag);
        dl_in_vec = v;
        @(posedge clock);
        model_edge(v);
        #1;
        check_output(tag);
    endtask

    // Reset is raised between edges so the clear must be visible before the next edge.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_output(tag);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [PROC_NUM-1:0] v;
        reset     = 1'b1;
        dl_in_vec = '0;
        #2;
        model_reset();
        check_output("por");
        #5;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) apply_stimulus(2'b00, "quiet");

        for (int i = 0; i < 4; i++) apply_stimulus(2'b10, "claim_b1");
        for (int i = 0; i < 3; i++) apply_stimulus(2'b00, "claim_b1_hold");
        apply_reset("reset_in_detected");
        for (int i = 0; i < 5; i++) apply_stimulus(2'b10, "redetect_b1");
        apply_reset("reset2");

        for (int i = 0; i < 4; i++) apply_stimulus(2'b11, "both_claim");
        for (int i = 0; i < 3; i++) apply_stimulus(2'b01, "both_drop_b1");
        apply_reset("reset3");

        apply_stimulus(2'b01, "abort_e1");
        apply_stimulus(2'b01, "abort_e2");
        apply_stimulus(2'b00, "abort_token");
        apply_stimulus(2'b01, "abort_gap");
        for (int i = 0; i < 5; i++) apply_stimulus(2'b01, "abort_recapture");
        apply_reset("reset4");

        apply_stimulus(2'b10, "midreset_e1");
        apply_stimulus(2'b10, "midreset_e2");
        apply_reset("reset_in_armed");
        apply_stimulus(2'b10, "midreset_b1_e1");
        apply_stimulus(2'b00, "midreset_b1_drop");
        apply_reset("reset_in_clear");

        for (int r = 0; r < 6; r++) begin
            v = PROC_NUM'($urandom_range(0, (1 << PROC_NUM) - 1));
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 3) == 0) v = PROC_NUM'($urandom_range(0, (1 << PROC_NUM) - 1));
                apply_stimulus(v, "random");
            end
            apply_reset("random_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dataflow_deadlock_arbiter.md
Name: dataflow_deadlock_arbiter

Overview:
Central arbitration/report end of the dataflow deadlock-detection protocol used in co-simulation. Collects per-process deadlock claims (dl_in_vec) from the per-process detect units and nominates a single origin process. It confirms the claim persists, then broadcasts a sticky global dl_detect_out, which the detect units use to freeze their dependency registers. Withdrawn claims are cancelled with a token_clear pulse.

Parameters:
PROC_NUM, 2, number of dataflow processes / detect units (>=1)
CONFIRM_CYCLES, 4, consecutive clock edges the origin claim must be sampled high before declaring deadlock (>=1)
CNT_W, 32, width of the free-running cycle counter

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-high reset
dl_in_vec  in  PROC_NUM  per-process deadlock claim, bit i from detect unit i
dl_detect_out  out  1  global deadlock declared (sticky until reset)
origin  out  PROC_NUM  one-hot nominated origin process; all-zero when none
token_clear  out  1  one-cycle pulse cancelling an aborted nomination
dl_proc_idx  out  max(1,clog2(PROC_NUM))  binary index of origin, valid while origin!=0
busy  out  1  high in ARMED, CLEAR or DETECTED

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset (async, immediate): state=IDLE; dl_detect_out=0, origin=0, token_clear=0, dl_proc_idx=0, busy=0; confirm counter and cycle counter cleared. Reset mid-operation aborts any state without emitting token_clear.
- All outputs registered; no combinational input-to-output paths.
- States: IDLE, ARMED, CLEAR, DETECTED.
- IDLE: if dl_in_vec!=0 at an edge: origin<=lowest-index set bit (one-hot), dl_proc_idx<=its index, confirm_cnt<=1, busy<=1. If CONFIRM_CYCLES==1 go directly to DETECTED (dl_detect_out<=1 on same edge); else go to ARMED. If dl_in_vec==0 remain IDLE.
- ARMED: only bit dl_in_vec[dl_proc_idx] is examined; other bits ignored.
  - bit high: confirm_cnt++; when the incremented value equals CONFIRM_CYCLES, dl_detect_out<=1, go to DETECTED.
  - bit low: origin<=0, token_clear<=1, go to CLEAR.
- CLEAR: token_clear<=0, busy<=0, go to IDLE; dl_in_vec is ignored on this edge (one-cycle re-arm gap). token_clear is therefore exactly one cycle wide.
- DETECTED: terminal until reset. dl_detect_out=1, origin/dl_proc_idx held, busy=1; all inputs ignored; token_clear never asserted.
- Simultaneous claims: lowest index wins; no fairness/rotation.
- Latency: dl_detect_out rises on the CONFIRM_CYCLES-th consecutive edge that samples the origin bit high (counting the IDLE capture edge).
- confirm_cnt width clog2(CONFIRM_CYCLES+1); cannot overflow since it stops at CONFIRM_CYCLES.
- Free-running cycle counter: CNT_W bits, increments every edge out of reset, wraps to 0 at 2^CNT_W-1.

Optional Feature:
DL_CYCLE_STAMP_EN: when defined, adds output detect_cycle [CNT_W-1:0], reset 0, loaded with the cycle counter value on the edge entering DETECTED and held until reset. When undefined, the port does not exist and the cycle counter is removed (no logic).

Test Plan:
- Reset, then dl_in_vec=2'b00 for 20 cycles -> all outputs stay 0, busy=0.
- PROC_NUM=2, CONFIRM_CYCLES=4, dl_in_vec=2'b10 held from edge 1 -> origin=2'b10, dl_proc_idx=1, busy=1 after edge 1; dl_detect_out=1 after edge 4; holds after dl_in_vec drops to 0.
- dl_in_vec=2'b11 at edge 1, held -> origin=2'b01, dl_proc_idx=0; dl_detect_out after edge 4; dropping bit 1 has no effect.
- dl_in_vec=2'b01 for edges 1-2, then 0 -> token_clear=1 for exactly the cycle after edge 3, origin=0, no detect; dl_in_vec=2'b01 at edge 4 ignored (CLEAR), re-captured at edge 5.
- Reach DETECTED, assert reset between edges -> all outputs 0 immediately, before next clock edge; after release, new claim on bit 1 re-detects normally.
- DL_CYCLE_STAMP_EN defined, CNT_W=4, claim starting at edge 15 with CONFIRM_CYCLES=4 -> counter wraps; detect_cycle=2 (counter value 18 mod 16) latched and held.
